imem_rom: RTL

IMEM_ROM -- requirements
Module: imem_rom

---
 rtl/imem_rom.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/imem_rom.sv
// Read-only instruction memory with a valid/ready fetch port and a programmable access latency.
// Define IMEM_FAULT_EN to report misaligned fetches as faults instead of silently aligning them.
module imem_rom #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ADDRLEN     = 8,
  parameter int unsigned WAIT_STATES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDRLEN-1:0] req_addr,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [XLEN-1:0]    rsp_data,
  output logic               rsp_fault,
  output logic               busy
);

  localparam int unsigned NBYTES = XLEN / 8;
  localparam int unsigned DEPTH  = 1 << ADDRLEN;
  localparam int unsigned CNTW   = 4;

`ifdef IMEM_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imem_rom: XLEN must be 32 or 64");
  end
  if (WAIT_STATES > 15) begin : g_bad_wait
    $error("imem_rom: WAIT_STATES must be in 0..15");
  end
  if (ADDRLEN < $clog2(XLEN / 8)) begin : g_bad_addrlen
    $error("imem_rom: ADDRLEN too small for one fetch word");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  // NOTE: the byte array is contents, not state; it is initialised once and never reset.
  logic [7:0] mem [DEPTH] = '{default: 8'h00};

  state_e             state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [ADDRLEN-1:0] addr_q, addr_d;
  logic               pend_fault_q, pend_fault_d;
  logic               valid_q, valid_d;
  logic [XLEN-1:0]    data_q, data_d;
  logic               fault_q, fault_d;

  logic [ADDRLEN-1:0] aligned_addr;
  logic               misaligned;
  logic               accept;
  logic [ADDRLEN-1:0] fetch_addr;
  logic               fetch_fault;
  logic               load_rsp;
  logic [XLEN-1:0]    fetch_word;

  assign aligned_addr = req_addr & ~ADDRLEN'(NBYTES - 1);
  assign misaligned   = FAULT_EN & (aligned_addr != req_addr);
  assign req_ready    = (state_q == S_IDLE) | ((state_q == S_RESP) & rsp_ready);
  assign accept       = req_valid & req_ready;

  // Little-endian word assembly; byte indices wrap so the top word stays in range.
  always_comb begin
    fetch_word = '0;
    for (int b = 0; b < NBYTES; b++) begin
      fetch_word[8*b +: 8] = mem[fetch_addr + ADDRLEN'(b)];
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    pend_fault_d = pend_fault_q;
    valid_d      = valid_q;
    data_d       = data_q;
    fault_d      = fault_q;
    fetch_addr   = addr_q;
    fetch_fault  = pend_fault_q;
    load_rsp     = 1'b0;

    unique case (state_q)
      S_IDLE, S_RESP: begin
        if ((state_q == S_RESP) && rsp_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
        if (accept) begin
          addr_d       = aligned_addr;
          pend_fault_d = misaligned;
          if (WAIT_STATES == 0) begin
            fetch_addr  = aligned_addr;
            fetch_fault = misaligned;
            load_rsp    = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNTW'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d    = '0;
          load_rsp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load_rsp) begin
      state_d = S_RESP;
      valid_d = 1'b1;
      data_d  = fetch_fault ? '0 : fetch_word;
      fault_d = fetch_fault;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      pend_fault_q <= 1'b0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      pend_fault_q <= pend_fault_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      fault_q      <= fault_d;
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_data  = data_q;
  assign rsp_fault = fault_q;
  assign busy      = (state_q != S_IDLE);

endmodule
